comp_encoder: RTL
=================

# comp_encoder

RVC instruction compressor and packer: the inverse of the instruction-fetch compressed decoder. It accepts a stream of 32-bit RV32I instructions, re-encodes eligible ones into 16-bit RVC form, and packs the resulting halfwords into little-endian 32-bit words for instruction memory. It sits between the program loader/assembler stream and the instruction-memory write port, so the core's fetch-side decoder can expand the code again.

## Interface
- `CNT_W`, 16, width of the compressed-instruction counter
- `PAD_HALF`, 16'h0001, halfword used to pad a flushed residue (C.NOP)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `compress_en`  in  1  1: compress eligible instructions; 0: pass every instruction through as 32-bit
- `in_valid`  in  1  input instruction valid
- `in_ready`  out  1  input accepted when `in_valid & in_ready`
- `in_ins`  in  32  RV32I instruction
- `flush`  in  1  level request to emit any pending halfword
- `out_valid`  out  1  packed word valid
- `out_ready`  in  1  sink accepts when `out_valid & out_ready`
- `out_word`  out  32  packed word; first halfword in [15:0]
- `residue_valid`  out  1  a halfword is pending in the packer
- `err`  out  1  one-cycle pulse: input dropped (in_ins[1:0] != 2'b11)
- `n_compressed`  out  CNT_W  count of instructions emitted in 16-bit form, wraps

## Operation
- Compression rules, applied in order; first match wins; otherwise 32-bit pass-through:
  - ebreak (0x00100073) -> 0x9002.
  - addi rd,x0,imm; rd!=0; imm in [-32,31] -> C.LI {010,imm[5],rd,imm[4:0],01}.
  - addi rd,rd,imm; rd!=0; imm!=0; imm in [-32,31] -> C.ADDI {000,imm[5],rd,imm[4:0],01}.
  - add rd,x0,rs2; rd,rs2!=0 -> C.MV {100,0,rd,rs2,10}. add rd,rd,rs2; rd,rs2!=0 -> C.ADD {100,1,rd,rs2,10}.
  - jalr x0,0(rs1) / jalr x1,0(rs1); rs1!=0 -> C.JR {100,0,rs1,00000,10} / C.JALR {100,1,rs1,00000,10}.
  - lw rd,off(rs1) / sw rs2,off(rs1); registers in x8..x15; off in [0,124]; off[1:0]=0 -> C.LW/C.SW {010/110,off[5:3],rs1[2:0],off[2],off[6],rd/rs2[2:0],00}.
  - PC-relative instructions (jal, branches, auipc) are never compressed: offsets would change.
- Packer FSM, states EMPTY and HALF (holding 16-bit `res`); on accepted input:
  - EMPTY, 16-bit c -> HALF, res=c, no output.
  - EMPTY, 32-bit w -> EMPTY, output w.
  - HALF, 16-bit c -> EMPTY, output {c,res}.
  - HALF, 32-bit w -> HALF, output {w[15:0],res}, res=w[31:16].
- Flush: in HALF with no input accepted this cycle, `flush`=1 and output slot free -> output {PAD_HALF,res}, go EMPTY. In EMPTY, flush is a no-op. Requester holds `flush` until `residue_valid`=0.
- Input with in_ins[1:0]!=2'b11: accepted, dropped, `err` pulses; state, output, counter unchanged.
- `n_compressed` increments by 1 per accepted compressed instruction (not pad), wraps at 2^CNT_W.

## Timing
- Single output register. `in_ready = !out_valid | out_ready` (combinational); same gating applies to flush.
- Latency: output word is valid the cycle after the accept completing it (or the flush cycle).
- `out_word` holds stable while `out_valid & !out_ready`.
- `out_valid` clears after a handshake unless a new word is loaded in the same cycle (back-to-back full throughput).
- Input accept and flush in the same cycle: input wins; flush is serviced in a later cycle.
- `compress_en` is sampled at accept; a change applies to the next instruction.
- Reset (any time, including mid-word): state EMPTY, res dropped, `out_valid`=0, `out_word`=0, `residue_valid`=0, `err`=0, `n_compressed`=0.

## Test plan
- addi x5,x5,3 (0x00328293) then addi x5,x5,-1 (0xFFF28293) -> one word 0x12FD028D; `n_compressed`=2; `residue_valid`=0.
- EMPTY, lui x5,1 (0x000012B7) -> out 0x000012B7 one cycle after accept; no count change.
- addi x5,x5,3 then 0x000012B7 -> out 0x12B7028D, `residue_valid`=1; then assert flush -> out 0x00010000, `residue_valid`=0.
- sw x9,4(x8) (0x00942223) then ebreak -> out 0x9002C044; jal x1,8 (0x008000EF) passes uncompressed; `compress_en`=0 makes 0x00328293 pass through unchanged.
- out_ready=0 with out_valid=1 -> in_ready=0, out_word stable for 5 cycles; release -> data delivered in order, no loss or duplication; in_ins=0x00000001 -> `err` pulse, nothing emitted.
- Reset asserted while in HALF with out_valid=1 -> all outputs go to reset values asynchronously; next instruction starts in EMPTY.

Source files
------------

// File: rtl/comp_encoder.sv
// RV32I -> RVC compressor with a halfword packer producing little-endian 32-bit words.
// A single output register carries each word; a 16-bit residue waits in HALF for its partner.
module comp_encoder #(
    parameter int          CNT_W    = 16,
    parameter logic [15:0] PAD_HALF = 16'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             compress_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             residue_valid,
    output logic             err,
    output logic [CNT_W-1:0] n_compressed
);

    typedef enum logic {EMPTY, HALF} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        res_reg, res_next;
    logic               out_valid_reg;
    logic [31:0]        out_word_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm_i, imm_s;
    logic        imm_i_6bit, off_i_ok, off_s_ok;
    logic        rd_c, rs1_c, rs2_c;
    logic        comp_hit;
    logic [15:0] comp_half;

    assign opcode = in_ins[6:0];
    assign rd     = in_ins[11:7];
    assign funct3 = in_ins[14:12];
    assign rs1    = in_ins[19:15];
    assign rs2    = in_ins[24:20];
    assign funct7 = in_ins[31:25];
    assign imm_i  = in_ins[31:20];
    assign imm_s  = {in_ins[31:25], in_ins[11:7]};

    assign imm_i_6bit = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);
    // Word-aligned offsets 0..124 fit the 5-bit scaled C.LW/C.SW field.
    assign off_i_ok   = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
    assign off_s_ok   = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);
    assign rd_c       = (rd[4:3] == 2'b01);
    assign rs1_c      = (rs1[4:3] == 2'b01);
    assign rs2_c      = (rs2[4:3] == 2'b01);

    always_comb begin
        comp_hit  = 1'b0;
        comp_half = 16'h0000;
        if (in_ins == 32'h0010_0073) begin
            comp_hit  = 1'b1;
            comp_half = 16'h9002;
        end else if (opcode == 7'b0010011 && funct3 == 3'b000 && rs1 == 5'd0
                     && rd != 5'd0 && imm_i_6bit) begin
            comp_hit  = 1'b1;
            comp_half = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opcode == 7'b0010011 && funct3 == 3'b000 && rs1 == rd
                     && rd != 5'd0 && imm_i != 12'd0 && imm_i_6bit) begin
            comp_hit  = 1'b1;
            comp_half = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'd0
                     && rd != 5'd0 && rs2 != 5'd0 && (rs1 == 5'd0 || rs1 == rd)) begin
            comp_hit  = 1'b1;
            comp_half = {3'b100, (rs1 != 5'd0), rd, rs2, 2'b10};
        end else if (opcode == 7'b1100111 && funct3 == 3'b000 && imm_i == 12'd0
                     && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1)) begin
            comp_hit  = 1'b1;
            comp_half = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end else if (opcode == 7'b0000011 && funct3 == 3'b010 && rd_c && rs1_c && off_i_ok) begin
            comp_hit  = 1'b1;
            comp_half = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (opcode == 7'b0100011 && funct3 == 3'b010 && rs2_c && rs1_c && off_s_ok) begin
            comp_hit  = 1'b1;
            comp_half = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
    end

    // Packer
    logic        accept, legal, use_half, load, cnt_inc;
    logic [31:0] load_word;

    assign in_ready = !out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;
    assign legal    = (in_ins[1:0] == 2'b11);
    assign use_half = compress_en & comp_hit;

    always_comb begin
        state_next = state_reg;
        res_next   = res_reg;
        load       = 1'b0;
        load_word  = out_word_reg;
        cnt_inc    = 1'b0;
        if (accept && legal) begin
            if (use_half) begin
                cnt_inc = 1'b1;
                if (state_reg == EMPTY) begin
                    state_next = HALF;
                    res_next   = comp_half;
                end else begin
                    state_next = EMPTY;
                    load       = 1'b1;
                    load_word  = {comp_half, res_reg};
                end
            end else begin
                load = 1'b1;
                if (state_reg == EMPTY) begin
                    load_word = in_ins;
                end else begin
                    load_word = {in_ins[15:0], res_reg};
                    res_next  = in_ins[31:16];
                end
            end
        end else if (!accept && flush && in_ready && state_reg == HALF) begin
            // Any accept (even a dropped illegal one) defers the flush a cycle.
            state_next = EMPTY;
            load       = 1'b1;
            load_word  = {PAD_HALF, res_reg};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            res_reg       <= 16'h0000;
            out_valid_reg <= 1'b0;
            out_word_reg  <= 32'h0000_0000;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg <= state_next;
            res_reg   <= res_next;
            err_reg   <= accept & !legal;
            if (load) begin
                out_valid_reg <= 1'b1;
                out_word_reg  <= load_word;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (cnt_inc)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_word      = out_word_reg;
    assign residue_valid = (state_reg == HALF);
    assign err           = err_reg;
    assign n_compressed  = cnt_reg;

endmodule
